// File: rtl/vote_controller.sv
// -----------------------------------------------------------------------------
// vote_controller
//
// Ballot sequencer for the EVM. It sits between the debounced per-candidate
// vote pulses and the tally storage. Each officer-issued ballot allows exactly
// one vote. Every candidate has a saturating tally counter, and the tallies can
// be read back while the machine is locked.
//
// Optional feature: define VOTE_TIMEOUT_EN to make an armed ballot expire
// after TIMEOUT_CYCLES cycles. Without it, an armed ballot waits indefinitely
// and timeout is tied low.
//
// Handshake: there is no backpressure. ballot_en and valid_vote are one-cycle
// pulses, sampled on the rising edge of clock. Each registered output appears
// on the cycle after the edge that sampled its cause.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   ballot_en    in   officer ballot-issue pulse
//   valid_vote   in   [NUM_CAND] vote pulses, bit i = candidate i
//   result_mode  in   officer readout request
//   result_sel   in   [$clog2(NUM_CAND)] candidate index for readout
//   armed        out  ballot armed, voter may press
//   vote_ack     out  vote accepted, held for HOLD_CYCLES cycles
//   ack_cand     out  [NUM_CAND] one-hot accepted candidate, valid with vote_ack
//   result_count out  [CNT_W] tally of the selected candidate (0 if not readable)
//   conflict     out  one-cycle pulse: multi-candidate press rejected
//   timeout      out  one-cycle pulse: armed ballot expired
//   dbg_state    out  [2] FSM state (0 LOCKED, 1 ARMED, 2 HOLD)
// -----------------------------------------------------------------------------
module vote_controller #(
    parameter int NUM_CAND       = 4,
    parameter int CNT_W          = 8,
    parameter int HOLD_CYCLES    = 100000000,
    parameter int TIMEOUT_CYCLES = 1000000000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ballot_en,
    input  logic [NUM_CAND-1:0]         valid_vote,
    input  logic                        result_mode,
    input  logic [$clog2(NUM_CAND)-1:0] result_sel,
    output logic                        armed,
    output logic                        vote_ack,
    output logic [NUM_CAND-1:0]         ack_cand,
    output logic [CNT_W-1:0]            result_count,
    output logic                        conflict,
    output logic                        timeout,
    output logic [1:0]                  dbg_state
);

    typedef enum logic [1:0] {
        S_LOCKED = 2'd0,
        S_ARMED  = 2'd1,
        S_HOLD   = 2'd2
    } state_e;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    // The hold counter is loaded with the last index and counts down to zero,
    // so vote_ack stays high for exactly HOLD_CYCLES cycles.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_e                state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]      tally_q [NUM_CAND];
    logic [CNT_W-1:0]      tally_d [NUM_CAND];
    logic                  armed_q, armed_d;
    logic                  vote_ack_q, vote_ack_d;
    logic [NUM_CAND-1:0]   ack_cand_q, ack_cand_d;
    logic [CNT_W-1:0]      result_count_q, result_count_d;
    logic                  conflict_q, conflict_d;
    logic                  accept;
    logic                  single_vote;
    logic                  multi_vote;

`ifdef VOTE_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, tmo_fire;
`endif

    // A one-hot test: the vector is nonzero, and clearing its lowest set bit
    // leaves zero.
    assign single_vote = (|valid_vote) &&
                         ((valid_vote & (valid_vote - NUM_CAND'(1))) == '0);
    assign multi_vote  = (|valid_vote) && !single_vote;

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_LOCKED;
            hold_cnt_q     <= '0;
            armed_q        <= 1'b0;
            vote_ack_q     <= 1'b0;
            ack_cand_q     <= '0;
            result_count_q <= '0;
            conflict_q     <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
`ifdef VOTE_TIMEOUT_EN
            tmo_cnt_q      <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            armed_q        <= armed_d;
            vote_ack_q     <= vote_ack_d;
            ack_cand_q     <= ack_cand_d;
            result_count_q <= result_count_d;
            conflict_q     <= conflict_d;
            for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= tally_d[i];
`ifdef VOTE_TIMEOUT_EN
            tmo_cnt_q      <= tmo_cnt_d;
            timeout_q      <= tmo_fire;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        accept     = 1'b0;
`ifdef VOTE_TIMEOUT_EN
        tmo_fire   = 1'b0;
`endif
        case (state_q)
            S_LOCKED: begin
                if (ballot_en && !result_mode) state_d = S_ARMED;
            end
            S_ARMED: begin
                // A single-bit vote takes priority over an expiry on the same
                // cycle.
                if (single_vote) begin
                    accept     = 1'b1;
                    state_d    = S_HOLD;
                    hold_cnt_d = HOLD_LAST;
                end
`ifdef VOTE_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_fire = 1'b1;
                    state_d  = S_LOCKED;
                end
`endif
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) state_d = S_LOCKED;
                else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
            default: state_d = S_LOCKED;
        endcase
`ifdef VOTE_TIMEOUT_EN
        // The counter runs only while the ballot stays armed. Conflict cycles
        // keep it running. It restarts from zero when the next ballot arms.
        tmo_cnt_d = ((state_q == S_ARMED) && (state_d == S_ARMED))
                    ? tmo_cnt_q + TMO_W'(1) : '0;
`endif
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        armed_d    = (state_d == S_ARMED);
        vote_ack_d = (state_d == S_HOLD);
        ack_cand_d = '0;
        if (accept)                  ack_cand_d = valid_vote;
        else if (state_d == S_HOLD)  ack_cand_d = ack_cand_q;
        conflict_d = (state_q == S_ARMED) && multi_vote;

        result_count_d = '0;
        if ((state_q == S_LOCKED) && result_mode && (int'(result_sel) < NUM_CAND))
            result_count_d = tally_q[result_sel];

        for (int i = 0; i < NUM_CAND; i++) begin
            tally_d[i] = tally_q[i];
            if (accept && valid_vote[i] && (tally_q[i] != '1))
                tally_d[i] = tally_q[i] + CNT_W'(1);
        end
    end

    assign armed        = armed_q;
    assign vote_ack     = vote_ack_q;
    assign ack_cand     = ack_cand_q;
    assign result_count = result_count_q;
    assign conflict     = conflict_q;
    assign dbg_state    = state_q;
`ifdef VOTE_TIMEOUT_EN
    assign timeout      = timeout_q;
`else
    assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_vote_controller.sv
// -----------------------------------------------------------------------------
// tb_vote_controller
//
// Directed bench for vote_controller with NUM_CAND=4, CNT_W=4, HOLD_CYCLES=4
// and TIMEOUT_CYCLES=10.
//
// When the driver issues stimulus, it records the responses it expects: queued
// ack candidates, queued readout values, and counts of expected arm, conflict
// and timeout pulses. A monitor samples the outputs on the falling edge. It
// consumes one expectation each time the DUT presents a response.
// -----------------------------------------------------------------------------
module tb_vote_controller;

    localparam int NC   = 4;
    localparam int CW   = 4;
    localparam int HOLD = 4;
    localparam int TMO  = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ballot_en = 1'b0;
    logic [NC-1:0] valid_vote = '0;
    logic          result_mode = 1'b0;
    logic [1:0]    result_sel = '0;
    logic          armed;
    logic          vote_ack;
    logic [NC-1:0] ack_cand;
    logic [CW-1:0] result_count;
    logic          conflict;
    logic          timeout;
    logic [1:0]    dbg_state;

    int errors = 0;
    int checks = 0;

    logic [CW-1:0] exp_q[$];       // expected readout values
    logic [NC-1:0] exp_ack_q[$];   // expected accepted candidates
    int exp_arm_cnt  = 0;
    int exp_conf_cnt = 0;
    int exp_tmo_cnt  = 0;

    vote_controller #(
        .NUM_CAND(NC), .CNT_W(CW), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .ballot_en(ballot_en),
        .valid_vote(valid_vote), .result_mode(result_mode),
        .result_sel(result_sel), .armed(armed), .vote_ack(vote_ack),
        .ack_cand(ack_cand), .result_count(result_count),
        .conflict(conflict), .timeout(timeout), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: actual=time limit reached required=finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs as sampled on the last rising edge.
    logic rm_prev  = 1'b0;
    logic rst_prev = 1'b0;
    always @(posedge clock) begin
        rm_prev  <= result_mode;
        rst_prev <= reset;
    end

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic arm_prev = 1'b0;
    logic ack_prev = 1'b0;
    int   ack_len  = 0;

    always @(negedge clock) begin
        logic ack_rise;
        if (!rst_prev) begin
            chk("reset_outputs_zero",
                int'({armed, vote_ack, ack_cand, result_count, conflict, timeout}), 0);
            ack_len  = 0;
            ack_prev = 1'b0;
            arm_prev = 1'b0;
        end else begin
            ack_rise = vote_ack && !ack_prev;
            if (ack_rise) begin
                if (exp_ack_q.size() == 0) chk("unexpected_ack", 1, 0);
                else chk("ack_cand", int'(ack_cand), int'(exp_ack_q.pop_front()));
            end
            if (vote_ack) ack_len++;
            else begin
                if (ack_prev) chk("ack_hold_len", ack_len, HOLD);
                ack_len = 0;
                chk("ack_cand_idle", int'(ack_cand), 0);
            end
            if (armed && !arm_prev) begin
                if (exp_arm_cnt == 0) chk("unexpected_arm", 1, 0);
                else exp_arm_cnt--;
            end
            if (!armed && arm_prev)
                chk("armed_drop_cause", int'(ack_rise || timeout), 1);
            if (conflict) begin
                if (exp_conf_cnt == 0) chk("unexpected_conflict", 1, 0);
                else exp_conf_cnt--;
            end
            if (timeout) begin
                if (exp_tmo_cnt == 0) chk("unexpected_timeout", 1, 0);
                else exp_tmo_cnt--;
            end
            if (rm_prev) begin
                if (exp_q.size() == 0) chk("unexpected_readout", 1, 0);
                else chk("result_count", int'(result_count), int'(exp_q.pop_front()));
            end
            ack_prev = vote_ack;
            arm_prev = armed;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic ballot(input bit expect_arm);
        if (expect_arm) exp_arm_cnt++;
        ballot_en = 1'b1;
        cycle();
        ballot_en = 1'b0;
    endtask

    task automatic press(input logic [NC-1:0] v);
        valid_vote = v;
        cycle();
        valid_vote = '0;
    endtask

    task automatic read(input logic [1:0] sel, input logic [CW-1:0] req);
        exp_q.push_back(req);
        result_mode = 1'b1;
        result_sel  = sel;
        cycle();
        result_mode = 1'b0;
        cycle();
    endtask

    // Complete ballot: arm, press two cycles after ballot_en, let HOLD finish.
    task automatic full_vote(input logic [NC-1:0] v);
        ballot(1'b1);
        cycle();
        exp_ack_q.push_back(v);
        press(v);
        repeat (HOLD + 1) cycle();
    endtask

    task automatic read_all(input logic [CW-1:0] t0, input logic [CW-1:0] t1,
                            input logic [CW-1:0] t2, input logic [CW-1:0] t3);
        read(2'd0, t0);
        read(2'd1, t1);
        read(2'd2, t2);
        read(2'd3, t3);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        read_all(4'd0, 4'd0, 4'd0, 4'd0);

        // A single vote for candidate 2.
        full_vote(4'b0100);
        read(2'd2, 4'd1);

        // A conflict, then a valid vote. A press during HOLD is ignored.
        ballot(1'b1);
        cycle();
        exp_conf_cnt++;
        press(4'b0011);
        cycle();
        exp_ack_q.push_back(4'b0001);
        press(4'b0001);
        press(4'b0010);
        repeat (HOLD) cycle();
        read_all(4'd1, 4'd0, 4'd1, 4'd0);

        // Saturation on candidate 3.
        for (int n = 0; n < 17; n++) full_vote(4'b1000);
        read_all(4'd1, 4'd0, 4'd1, 4'd15);

        // Votes while LOCKED are ignored.
        press(4'b0010);
        press(4'b1111);
        cycle();
        read(2'd1, 4'd0);

        // ballot_en during readout is ignored. The readout itself returns tally[3].
        exp_q.push_back(4'd15);
        result_mode = 1'b1;
        result_sel  = 2'd3;
        ballot_en   = 1'b1;
        cycle();
        ballot_en   = 1'b0;
        result_mode = 1'b0;
        repeat (3) cycle();

        // A readout request while ARMED returns 0. The ballot then completes.
        ballot(1'b1);
        cycle();
        read(2'd2, 4'd0);
        exp_ack_q.push_back(4'b0010);
        press(4'b0010);
        repeat (HOLD + 1) cycle();
        read(2'd1, 4'd1);

`ifdef VOTE_TIMEOUT_EN
        // After 10 idle armed cycles, the ballot expires.
        ballot(1'b1);
        exp_tmo_cnt++;
        repeat (TMO + 2) cycle();
        read_all(4'd1, 4'd1, 4'd1, 4'd15);
        // A vote on the 10th armed cycle still wins.
        ballot(1'b1);
        repeat (TMO - 1) cycle();
        exp_ack_q.push_back(4'b0001);
        press(4'b0001);
        repeat (HOLD + 1) cycle();
`else
        // Without the timeout, an armed ballot persists well past 10 cycles.
        ballot(1'b1);
        repeat (TMO + 4) cycle();
        exp_ack_q.push_back(4'b0001);
        press(4'b0001);
        repeat (HOLD + 1) cycle();
`endif
        read_all(4'd2, 4'd1, 4'd1, 4'd15);

        // A reset during HOLD drops vote_ack and clears the tallies.
        ballot(1'b1);
        cycle();
        exp_ack_q.push_back(4'b0100);
        press(4'b0100);
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        read_all(4'd0, 4'd0, 4'd0, 4'd0);

        repeat (3) cycle();
        chk("pending_readouts", exp_q.size(), 0);
        chk("pending_acks", exp_ack_q.size(), 0);
        chk("pending_arms", exp_arm_cnt, 0);
        chk("pending_conflicts", exp_conf_cnt, 0);
        chk("pending_timeouts", exp_tmo_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
